// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory interface between two requesters using
//   round-robin arbitration. The winning request is latched, presented to
//   memory from registers, and the one-cycle memory response is routed back
//   to the granted requester. A watchdog terminates transactions the memory
//   never answers.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   rN_addr/rmask/wmask/wdata : requester N request (N = 0, 1)
//   rN_rdata, rN_resp       : requester N read data and completion pulse
//   mem_addr/rmask/wmask/wdata: memory request, driven from registers only
//   mem_rdata, mem_resp     : memory read data and one-cycle completion
//   timeout_err             : one-cycle pulse when the watchdog fires
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] r0_addr,
    input  logic [3:0]  r0_rmask,
    input  logic [3:0]  r0_wmask,
    input  logic [31:0] r0_wdata,
    output logic [31:0] r0_rdata,
    output logic        r0_resp,

    input  logic [31:0] r1_addr,
    input  logic [3:0]  r1_rmask,
    input  logic [3:0]  r1_wmask,
    input  logic [31:0] r1_wdata,
    output logic [31:0] r1_rdata,
    output logic        r1_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic        timeout_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Watchdog compare value; only meaningful when the watchdog is enabled.
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [0:0]  state_q,      state_d;
    logic        grant_q,      grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] cnt_q,        cnt_d;
    logic [31:0] addr_q,       addr_d;
    logic [3:0]  rmask_q,      rmask_d;
    logic [3:0]  wmask_q,      wmask_d;
    logic [31:0] wdata_q,      wdata_d;

    logic req0_s;
    logic req1_s;
    logic win_s;
    logic busy_s;
    logic complete_s;
    logic timeout_s;

    assign req0_s = (|r0_rmask) | (|r0_wmask);
    assign req1_s = (|r1_rmask) | (|r1_wmask);
    assign busy_s = (state_q == BUSY);

    // Completion and watchdog decode; mem_resp wins over a coincident timeout.
    always_comb begin
        complete_s = busy_s & mem_resp;
        if (TO_EN) begin
            timeout_s = busy_s & ~mem_resp & (cnt_q == TO_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Tie goes to the requester that did not win last time; a lone requester wins.
    always_comb begin
        if (req0_s && req1_s) begin
            win_s = ~last_grant_q;
        end else begin
            win_s = req1_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for response or timeout in BUSY.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rmask_d      = rmask_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (req0_s || req1_s) begin
                    state_d      = BUSY;
                    grant_d      = win_s;
                    last_grant_d = win_s;
                    cnt_d        = 16'd0;
                    if (win_s) begin
                        addr_d  = r1_addr;
                        rmask_d = r1_rmask;
                        wmask_d = r1_wmask;
                        wdata_d = r1_wdata;
                    end else begin
                        addr_d  = r0_addr;
                        rmask_d = r0_rmask;
                        wmask_d = r0_wmask;
                        wdata_d = r0_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (complete_s || timeout_s) begin
                    // Clearing the latched masks makes the memory port idle
                    // straight from registers on the next cycle.
                    state_d = IDLE;
                    rmask_d = 4'h0;
                    wmask_d = 4'h0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rmask_d = 4'h0;
                wmask_d = 4'h0;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 16'd0;
            addr_q       <= 32'h0;
            rmask_q      <= 4'h0;
            wmask_q      <= 4'h0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rmask_q      <= rmask_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rmask = rmask_q;
    assign mem_wmask = wmask_q;
    assign mem_wdata = wdata_q;

    // Route the response to the granted requester; a timeout returns zero data.
    always_comb begin
        r0_resp  = (complete_s | timeout_s) & ~grant_q;
        r1_resp  = (complete_s | timeout_s) & grant_q;
        r0_rdata = 32'h0;
        r1_rdata = 32'h0;
        if (complete_s && !grant_q) begin
            r0_rdata = mem_rdata;
        end else if (complete_s && grant_q) begin
            r1_rdata = mem_rdata;
        end else begin
            r0_rdata = 32'h0;
            r1_rdata = 32'h0;
        end
    end

    assign timeout_err = timeout_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_rmask, r0_wmask;
    logic        r0_resp;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_rmask, r1_wmask;
    logic        r1_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        mem_resp;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(32'd8)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_rmask(r0_rmask), .r0_wmask(r0_wmask),
        .r0_wdata(r0_wdata), .r0_rdata(r0_rdata), .r0_resp(r0_resp),
        .r1_addr(r1_addr), .r1_rmask(r1_rmask), .r1_wmask(r1_wmask),
        .r1_wdata(r1_wdata), .r1_rdata(r1_rdata), .r1_resp(r1_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of an IDLE cycle with requests already driven.
    // Memory answers in the second BUSY cycle; leaves at the next IDLE negedge.
    task automatic txn(input logic g, input logic [31:0] rd);
        #1;
        check_val("idle_rmask", 32'(mem_rmask), 32'h0);
        check_val("idle_wmask", 32'(mem_wmask), 32'h0);
        @(negedge clk); #1;
        check_val("busy_addr",  mem_addr,        g ? r1_addr : r0_addr);
        check_val("busy_rmask", 32'(mem_rmask),  32'(g ? r1_rmask : r0_rmask));
        check_val("busy_wmask", 32'(mem_wmask),  32'(g ? r1_wmask : r0_wmask));
        check_val("busy_wdata", mem_wdata,       g ? r1_wdata : r0_wdata);
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = rd;
        #1;
        check_val("r0_resp",  32'(r0_resp),  32'(!g));
        check_val("r1_resp",  32'(r1_resp),  32'(g));
        check_val("r0_rdata", r0_rdata,      g ? 32'h0 : rd);
        check_val("r1_rdata", r1_rdata,      g ? rd : 32'h0);
        check_val("txn_terr", 32'(timeout_err), 32'h0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        r0_addr = 32'h0; r0_rmask = 4'h0; r0_wmask = 4'h0; r0_wdata = 32'h0;
        r1_addr = 32'h0; r1_rmask = 4'h0; r1_wmask = 4'h0; r1_wdata = 32'h0;
        mem_rdata = 32'h0; mem_resp = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_mem_rmask", 32'(mem_rmask), 32'h0);
        check_val("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        check_val("rst_mem_addr",  mem_addr,       32'h0);
        check_val("rst_mem_wdata", mem_wdata,      32'h0);
        check_val("rst_r0_resp",   32'(r0_resp),   32'h0);
        check_val("rst_r1_resp",   32'(r1_resp),   32'h0);
        check_val("rst_terr",      32'(timeout_err), 32'h0);

        // Single read: request at T, memory answers at T+3
        @(negedge clk);
        rst = 1'b0;
        r0_addr = 32'h1ECE_B000; r0_rmask = 4'hF;
        #1;
        check_val("t1_T_rmask", 32'(mem_rmask), 32'h0);
        @(negedge clk); #1;
        check_val("t1_T1_addr",  mem_addr,       32'h1ECE_B000);
        check_val("t1_T1_rmask", 32'(mem_rmask), 32'hF);
        check_val("t1_T1_resp",  32'(r0_resp),   32'h0);
        @(negedge clk); #1;
        check_val("t1_T2_resp",  32'(r0_resp),   32'h0);
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("t1_T3_r0_resp",  32'(r0_resp), 32'h1);
        check_val("t1_T3_r0_rdata", r0_rdata,     32'hDEAD_BEEF);
        check_val("t1_T3_r1_resp",  32'(r1_resp), 32'h0);
        check_val("t1_T3_r1_rdata", r1_rdata,     32'h0);
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = 32'h0; r0_rmask = 4'h0;
        #1;
        check_val("t1_T4_rmask", 32'(mem_rmask), 32'h0);

        // Simultaneous requests after reset: grants alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r0_addr = 32'h0000_0040; r0_rmask = 4'hF;
        r1_addr = 32'h0000_0080; r1_wmask = 4'b0011; r1_wdata = 32'h0000_1234;
        txn(1'b0, 32'h1111_0000);
        txn(1'b1, 32'h2222_0000);
        txn(1'b0, 32'h3333_0000);
        txn(1'b1, 32'h4444_0000);

        // r1 continuous, single r0 request injected
        r0_rmask = 4'h0;
        txn(1'b1, 32'h5555_0000);
        txn(1'b1, 32'h6666_0000);
        r0_addr = 32'h0000_0500; r0_rmask = 4'h3;
        txn(1'b0, 32'h7777_0000);
        r0_rmask = 4'h0;
        txn(1'b1, 32'h8888_0000);
        r1_wmask = 4'h0;

        // Requester input change during BUSY is ignored
        r0_addr = 32'h0000_0100; r0_rmask = 4'hF;
        #1;
        check_val("t4_idle_rmask", 32'(mem_rmask), 32'h0);
        @(negedge clk); #1;
        check_val("t4_addr_b1", mem_addr, 32'h0000_0100);
        r0_addr = 32'h0000_0200;
        @(negedge clk); #1;
        check_val("t4_addr_b2", mem_addr, 32'h0000_0100);
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        check_val("t4_addr_b3", mem_addr,      32'h0000_0100);
        check_val("t4_r0_resp", 32'(r0_resp),  32'h1);
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = 32'h0; r0_rmask = 4'h0;

        // Watchdog: memory never answers, fires on the 8th BUSY cycle
        r0_addr = 32'h0000_0040; r0_rmask = 4'hF;
        #1;
        check_val("wd_idle_rmask", 32'(mem_rmask), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            mem_rdata = 32'hBAD0_BAD0;
            #1;
            check_val("wd_rmask",  32'(mem_rmask),   32'hF);
            check_val("wd_r0_resp", 32'(r0_resp),    (i == 8) ? 32'h1 : 32'h0);
            check_val("wd_terr",    32'(timeout_err), (i == 8) ? 32'h1 : 32'h0);
            check_val("wd_r0_rdata", r0_rdata,       32'h0);
            check_val("wd_r1_resp", 32'(r1_resp),    32'h0);
        end
        @(negedge clk);
        r0_rmask = 4'h0; mem_rdata = 32'h0;
        #1;
        check_val("wd_after_rmask", 32'(mem_rmask),   32'h0);
        check_val("wd_after_terr",  32'(timeout_err), 32'h0);
        check_val("wd_after_resp",  32'(r0_resp),     32'h0);

        // Watchdog boundary: mem_resp on the 8th cycle completes normally
        r0_rmask = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 8) begin
                mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
            end else begin
                mem_resp = 1'b0;
            end
            #1;
            check_val("wd2_r0_resp", 32'(r0_resp),    (i == 8) ? 32'h1 : 32'h0);
            check_val("wd2_terr",    32'(timeout_err), 32'h0);
        end
        check_val("wd2_r0_rdata", r0_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = 32'h0; r0_rmask = 4'h0;
        #1;
        check_val("wd2_after_rmask", 32'(mem_rmask), 32'h0);

        // Reset in the 2nd BUSY cycle drops the transaction
        r0_addr = 32'h0000_0900; r0_rmask = 4'hF;
        @(negedge clk); #1;
        check_val("rb_b1_rmask", 32'(mem_rmask), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rb_b2_resp", 32'(r0_resp), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        r1_addr = 32'h0000_0A00; r1_wmask = 4'b0011; r1_wdata = 32'h0000_1234;
        txn(1'b0, 32'h9999_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory interface between two requesters, e.g. an instruction-fetch path and a data load/store path of the multicycle RV32I core, or the core and a test-loader.
- Uses the same request/response protocol as the core's memory port: address, read/write byte masks, write data, read data, one-cycle resp.
- Arbitrates round-robin, latches the winning request, sequences it to memory, and routes the response back.
- Includes a watchdog that terminates transactions the memory never answers.

Parameters:
TIMEOUT_CYCLES, 1024, BUSY cycles without mem_resp before forced termination; 0 disables; max 65535 (16-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
r0_addr  in  32  requester 0 byte address
r0_rmask  in  4  requester 0 read byte mask
r0_wmask  in  4  requester 0 write byte mask
r0_wdata  in  32  requester 0 write data
r0_rdata  out  32  requester 0 read data
r0_resp  out  1  requester 0 completion pulse
r1_addr, r1_rmask, r1_wmask, r1_wdata, r1_rdata, r1_resp  same widths/directions, requester 1
mem_addr  out  32  memory address
mem_rmask  out  4  memory read mask
mem_wmask  out  4  memory write mask
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
mem_resp  in  1  memory completion, valid one cycle
timeout_err  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), timeout counter=0, latched request regs=0.
  - mem_rmask=0, mem_wmask=0, mem_addr=0, mem_wdata=0, r0/r1_resp=0, r0/r1_rdata=0, timeout_err=0.
- Request valid: rN_req = |rN_rmask | |rN_wmask. A requester holds its signals stable until it sees rN_resp.
- States: IDLE, BUSY.
- IDLE:
  - mem_* masks are 0. mem_resp is ignored.
  - If any req is valid, pick a grant:
    - Only one valid: that requester wins.
    - Both valid: the requester != last_grant wins.
  - At the clock edge, latch the winner's addr/rmask/wmask/wdata, set grant and last_grant=winner, clear the counter, go to BUSY.
- BUSY:
  - mem_addr/rmask/wmask/wdata are driven from latched registers only. Requester input changes are ignored.
  - Addresses and masks pass through unmodified; alignment is the memory's concern. rmask and wmask both nonzero is passed through as-is.
- Completion:
  - Any BUSY cycle with mem_resp=1: r{grant}_resp=1 and r{grant}_rdata=mem_rdata, combinationally in the same cycle. The non-granted requester sees resp=0 and rdata=0.
  - Next state is IDLE.
- Latency: a request seen in cycle T appears on mem_* in T+1. The response returns to the requester in the same cycle as mem_resp. Minimum turnaround is 3 cycles per access including the IDLE cycle.
- Withdrawal: if the granted requester drops its masks during BUSY, the transaction still completes and the resp pulse is still issued.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each BUSY cycle with mem_resp=0.
  - In the BUSY cycle where counter==TIMEOUT_CYCLES-1 and mem_resp=0, for that cycle only: r{grant}_resp=1, r{grant}_rdata=32'h0, timeout_err=1. Next state is IDLE.
  - mem_resp in that same cycle takes priority: normal completion, no error.
- Reset mid-BUSY: the transaction is dropped with no resp pulse. Memory masks go to 0 on the next cycle.
- No combinational path from requester inputs to mem_* outputs.
- rN_resp depends combinationally only on mem_resp and registered state.

Test Plan:
- Single read: r0 rmask=4'hF, addr=0x1ECEB000 at T → mem_addr=0x1ECEB000, mem_rmask=F at T+1. Memory answers mem_resp=1, rdata=0xDEADBEEF at T+3 → r0_resp=1, r0_rdata=0xDEADBEEF at T+3; r1_resp=0; IDLE at T+4.
- Simultaneous requests after reset: r0 read, r1 write wmask=4'b0011, wdata=0x1234 → r0 granted first. r1 is granted in the next IDLE, with mem_wmask=3, mem_wdata=0x1234. Repeat three times; grants alternate 0,1,0,1.
- Continuous r1 requests with a single r0 request injected → r0 is granted at the next arbitration point; r1 is not starved, it gets the following slot.
- Input change during BUSY: r0 changes addr 0x100→0x200 mid-transaction → mem_addr stays 0x100 until resp.
- Watchdog with TIMEOUT_CYCLES=8 and memory never responding → exactly 8 BUSY cycles. On the 8th: r0_resp=1, r0_rdata=0, timeout_err=1 for one cycle; then IDLE. Repeat with mem_resp arriving on the 8th cycle → normal completion, timeout_err=0.
- Reset asserted in the 2nd BUSY cycle → no resp. The next cycle has mem masks 0 and state IDLE. The next simultaneous request grants r0.
